// File: rtl/distribute_1xn_dst_tag_buf.sv
// Destination-tag distribute switch, radix 2**SEL_WIDTH, with a FIFO on every output.
// The top SEL_WIDTH tag bits pick the output and the remaining tag bits travel with the word.
// Broadcast mode writes the same entry into every output FIFO in one cycle.
module distribute_1xn_dst_tag_buf #(
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned DESTINATION_TAG_WIDTH = 3,
    parameter int unsigned SEL_WIDTH             = 1,
    parameter int unsigned FIFO_DEPTH            = 4,
    localparam int unsigned NUM_DATA_OUT         = 2 ** SEL_WIDTH,
    localparam int unsigned OUT_COMMAND_WIDTH    = (DESTINATION_TAG_WIDTH > SEL_WIDTH)
                                                   ? (DESTINATION_TAG_WIDTH - SEL_WIDTH) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_en,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [DATA_WIDTH-1:0]                     i_data_bus,
    input  logic [DESTINATION_TAG_WIDTH-1:0]          i_cmd,
    input  logic                                      i_bcast,
    output logic [NUM_DATA_OUT-1:0]                   o_valid,
    input  logic [NUM_DATA_OUT-1:0]                   i_ready,
    output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]        o_data_bus,
    output logic [NUM_DATA_OUT*OUT_COMMAND_WIDTH-1:0] o_cmd
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OUT_COMMAND_WIDTH-1:0] cmd;
        logic [DATA_WIDTH-1:0]        data;
    } entry_t;

    logic [SEL_WIDTH-1:0]    sel;
    entry_t                  in_entry;
    logic [NUM_DATA_OUT-1:0] full;
    logic [NUM_DATA_OUT-1:0] nonempty;
    logic [NUM_DATA_OUT-1:0] push;
    logic [NUM_DATA_OUT-1:0] pop;
    logic                    accept;

    assign sel           = i_cmd[DESTINATION_TAG_WIDTH-1 -: SEL_WIDTH];
    assign in_entry.data = i_data_bus;

    // Forwarded tag is the tag remainder, or a constant zero when the whole tag is consumed
    generate
        if (DESTINATION_TAG_WIDTH > SEL_WIDTH) begin : g_fwd
            assign in_entry.cmd = i_cmd[OUT_COMMAND_WIDTH-1:0];
        end else begin : g_no_fwd
            assign in_entry.cmd = '0;
        end
    endgenerate

    // Acceptance uses registered occupancy only, so there is no i_ready -> o_ready path
    always_comb begin
        o_ready = 1'b0;
        if (rst && i_en) begin
            o_ready = i_bcast ? ~(|full) : ~full[sel];
        end
    end

    assign accept = i_valid & o_ready;

    // Steer an accepted word into the selected FIFO, or into all of them on broadcast
    always_comb begin
        push = '0;
        if (accept) begin
            if (i_bcast) begin
                push = '1;
            end else begin
                push[sel] = 1'b1;
            end
        end
    end

    assign o_valid = nonempty;
    assign pop     = nonempty & i_ready;

    generate
        for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_out
            entry_t             mem [FIFO_DEPTH];
            logic [PTR_W-1:0]   wr_ptr;
            logic [PTR_W-1:0]   rd_ptr;
            logic [CNT_W-1:0]   count;
            entry_t             head;

            assign nonempty[k] = (count != '0);
            assign full[k]     = (count == CNT_W'(FIFO_DEPTH));

            // Pointer and occupancy tracking; reset discards everything queued
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push[k]) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (pop[k]) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    if (push[k] && !pop[k]) begin
                        count <= count + CNT_W'(1);
                    end else if (!push[k] && pop[k]) begin
                        count <= count - CNT_W'(1);
                    end
                end
            end

            // Storage needs no reset: reads are masked while the FIFO is empty
            always_ff @(posedge clk) begin
                if (push[k]) begin
                    mem[wr_ptr] <= in_entry;
                end
            end

            assign head = nonempty[k] ? mem[rd_ptr] : '0;
            assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]             = head.data;
            assign o_cmd[k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH]    = head.cmd;
        end
    endgenerate

endmodule
